mips_multicycle_core: RTL

Multi-cycle successor to the single-cycle MIPS core. It executes the same MIPS-I integer subset through a five-state FSM over one shared, handshaked memory port, so instruction and data memories may have arbitrary wait states. It sits inside the mips machine in place of the single-cycle core and contains its own 32x32 register file. Start PC and illegal-opcode policy are parametrised.

---
 rtl/mips_multicycle_core.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-I subset core: FETCH/DECODE/EXEC/MEM/WB over one handshaked port.
// Optional perf counters enabled by defining MIPS_MC_PERF_EN.
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst_b,
  output logic [31:0]     mem_addr,
  output logic            mem_req,
  output logic            mem_we,
  output logic [0:3][7:0] mem_data_in,
  input  logic [0:3][7:0] mem_data_out,
  input  logic            mem_ready,
  output logic            halted
`ifdef MIPS_MC_PERF_EN
  ,
  output logic [31:0]     cycle_count,
  output logic [31:0]     retired_count
`endif
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t      state;
  logic [31:0] pc, ir, a, b, alu_out, mdr;
  logic [31:0] rf [32];

  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd, wb_dst;
  logic [31:0] imm_se, br_tgt, j_tgt, alu_res;
  logic        is_r, is_sys, is_addi, is_lw, is_sw, is_beq, is_j, legal;
  logic        f_sub, f_and, f_or, f_slt;

  always_comb begin
    op      = ir[31:26];
    fn      = ir[5:0];
    rs      = ir[25:21];
    rt      = ir[20:16];
    rd      = ir[15:11];
    f_sub   = (op == 6'h00) && (fn == 6'h22);
    f_and   = (op == 6'h00) && (fn == 6'h24);
    f_or    = (op == 6'h00) && (fn == 6'h25);
    f_slt   = (op == 6'h00) && (fn == 6'h2A);
    is_r    = f_sub || f_and || f_or || f_slt ||
              ((op == 6'h00) && (fn == 6'h20));
    is_sys  = (op == 6'h00) && (fn == 6'h0C);
    is_addi = op == 6'h08;
    is_lw   = op == 6'h23;
    is_sw   = op == 6'h2B;
    is_beq  = op == 6'h04;
    is_j    = op == 6'h02;
    legal   = is_r || is_sys || is_addi || is_lw ||
              is_sw || is_beq || is_j;
    imm_se  = {{16{ir[15]}}, ir[15:0]};
    // pc already holds PC+4 once the fetch has completed
    br_tgt  = pc + {imm_se[29:0], 2'b00};
    j_tgt   = {pc[31:28], ir[25:0], 2'b00};
    wb_dst  = is_r ? rd : rt;
  end

  always_comb begin
    alu_res = a + (is_r ? b : imm_se);
    unique case (1'b1)
      f_sub:   alu_res = a - b;
      f_and:   alu_res = a & b;
      f_or:    alu_res = a | b;
      f_slt:   alu_res = {31'b0, $signed(a) < $signed(b)};
      default: ;
    endcase
  end

  // Outputs derive from held registers, so they stay stable while stalled
  assign mem_req     = rst_b && (state == S_FETCH || state == S_MEM);
  assign mem_we      = (state == S_MEM) && is_sw;
  assign mem_addr    = (state == S_MEM) ? {alu_out[31:2], 2'b00} : pc;
  assign mem_data_in = b;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
      halted  <= 1'b0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      unique case (state)
        S_FETCH: if (mem_req && mem_ready) begin
          ir    <= mem_data_out;
          pc    <= pc + 32'd4;
          state <= S_DECODE;
        end
        S_DECODE: begin
          a <= rf[rs];
          b <= rf[rt];
          if (is_j) begin
            pc    <= j_tgt;
            state <= S_FETCH;
          end else if (is_sys || (!legal && HALT_ON_ILLEGAL)) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else if (!legal) begin
            state <= S_FETCH;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          alu_out <= alu_res;
          if (is_beq) begin
            if (a == b) pc <= br_tgt;
            state <= S_FETCH;
          end else if (is_lw || is_sw) begin
            state <= S_MEM;
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: if (mem_req && mem_ready) begin
          if (is_lw) begin
            mdr   <= mem_data_out;
            state <= S_WB;
          end else begin
            state <= S_FETCH;
          end
        end
        S_WB: begin
          if (wb_dst != 5'd0) rf[wb_dst] <= is_lw ? mdr : alu_out;
          state <= S_FETCH;
        end
        S_HALT: ;
        default: state <= S_HALT;
      endcase
    end
  end

`ifdef MIPS_MC_PERF_EN
  logic retire;

  always_comb begin
    retire = 1'b0;
    unique case (state)
      S_DECODE: retire = is_j || is_sys || (!legal && !HALT_ON_ILLEGAL);
      S_EXEC:   retire = is_beq;
      S_MEM:    retire = mem_req && mem_ready && is_sw;
      S_WB:     retire = 1'b1;
      default:  retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cycle_count   <= '0;
      retired_count <= '0;
    end else if (!halted) begin
      cycle_count <= cycle_count + 32'd1;
      if (retire) retired_count <= retired_count + 32'd1;
    end
  end
`endif

endmodule
